instruction_fetch_unit: RTL and testbench

Parametrised instruction fetch stage. It holds the program counter and issues one read per cycle to a synchronous instruction memory with one-cycle read latency. Returned instructions are presented to decode through a valid/ready handshake, with a one-entry skid buffer so decode stalls lose no instruction. It accepts PC redirects (branch/jump) that flush any in-flight and buffered fetches, and sits between the instruction ROM and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 tb/tb_instruction_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, one-cycle-latency IMEM read, and a
// valid/ready output register backed by a one-entry skid buffer.
module instruction_fetch_unit #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus1,
   input  logic              id_ready
);

   logic [ADDR_W-1:0] pc;
   logic              req_v;
   logic [ADDR_W-1:0] req_pc;
   logic              out_v;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              skid_v;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc;
   logic              issue;
   logic              consume;

   // Stop issuing once the returning word would have nowhere to land.
   assign consume   = !out_v || id_ready;
   assign issue     = redirect_valid || (!skid_v && !(out_v && !id_ready && req_v));
   assign imem_en   = rst_n && issue;
   assign imem_addr = redirect_valid ? redirect_pc : pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         req_v  <= 1'b0;
         req_pc <= RESET_PC;
      end else if (issue) begin
         pc     <= imem_addr + 1'b1;
         req_v  <= 1'b1;
         req_pc <= imem_addr;
      end else begin
         req_v  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v      <= 1'b0;
         out_instr  <= '0;
         out_pc     <= RESET_PC;
         skid_v     <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= RESET_PC;
      end else if (redirect_valid) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else if (consume) begin
         // Skid is older than the returning word, so it drains first.
         if (skid_v) begin
            out_v     <= 1'b1;
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
            skid_v    <= req_v;
            if (req_v) begin
               skid_instr <= imem_data;
               skid_pc    <= req_pc;
            end
         end else begin
            out_v <= req_v;
            if (req_v) begin
               out_instr <= imem_data;
               out_pc    <= req_pc;
            end
         end
      end else if (req_v) begin
         skid_v     <= 1'b1;
         skid_instr <= imem_data;
         skid_pc    <= req_pc;
      end
   end

   assign if_valid    = out_v;
   assign if_instr    = out_instr;
   assign if_pc       = out_pc;
   assign if_pc_plus1 = out_pc + 1'b1;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: scoreboard of expected fetch order plus
// table-driven redirect vectors and hand-written stall/reset sequences.
module tb_instruction_fetch_unit;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 10;
   localparam logic [9:0]  RPC = 10'h010;

   logic          clk;
   logic          rst_n;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_data;
   logic          if_valid;
   logic [DW-1:0] if_instr;
   logic [AW-1:0] if_pc;
   logic [AW-1:0] if_pc_plus1;
   logic          id_ready;

   instruction_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
      .id_ready(id_ready)
   );

   function automatic logic [31:0] rom(input logic [9:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (imem_en) imem_data <= rom(imem_addr);

   int         n_pass  = 0;
   int         n_total = 0;
   int         cnt_30  = 0;
   logic [9:0] exp_q[$];
   bit         mon_en     = 1'b0;
   bit         prev_stall = 1'b0;
   bit         prev_redir = 1'b0;
   logic [9:0] prev_pc;
   logic [9:0] mon_e;
   logic [9:0] mon_e1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic fill_q(input logic [9:0] start);
      exp_q.delete();
      for (int unsigned i = 0; i < 64; i++) exp_q.push_back(start + 10'(i));
   endtask

   // Transfer monitor: every accepted instruction must be the next expected PC.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (prev_stall && !prev_redir) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", {22'd0, if_pc}, {22'd0, prev_pc});
         end
         if (if_valid && id_ready) begin
            if (if_pc == 10'h030) cnt_30++;
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow: got pc 0x%0h expected no transfer", if_pc);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_e1 = mon_e + 10'd1;
               chk("sb_pc", {22'd0, if_pc}, {22'd0, mon_e});
               chk("sb_instr", if_instr, rom(mon_e));
               chk("sb_plus1", {22'd0, if_pc_plus1}, {22'd0, mon_e1});
            end
         end
         prev_stall = if_valid && !id_ready;
         prev_redir = redirect_valid;
         prev_pc    = if_pc;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [9:0] a);
      redirect_valid = 1'b1;
      redirect_pc    = a;
      tick();
      redirect_valid = 1'b0;
      fill_q(a);
   endtask

   task automatic wait_pc(input logic [9:0] a, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (if_valid && if_pc == a) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (!found) begin
         n_total++;
         $display("FAIL %s: timeout, last pc 0x%0h expected 0x%0h", name, if_pc, a);
      end
   endtask

   typedef struct {
      logic [9:0]  target;
      logic [9:0]  exp_plus1;
      logic [31:0] exp_instr;
   } rd_vec_t;

   rd_vec_t tbl[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int iss;
      tbl[0] = '{10'h000, 10'h001, 32'hC0DE_0000};
      tbl[1] = '{10'h155, 10'h156, 32'hC0DE_0155};
      tbl[2] = '{10'h3FE, 10'h3FF, 32'hC0DE_03FE};
      tbl[3] = '{10'h3FF, 10'h000, 32'hC0DE_03FF};
      tbl[4] = '{10'h200, 10'h201, 32'hC0DE_0200};

      rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_pc", {22'd0, if_pc}, 32'h010);
      chk("rst_plus1", {22'd0, if_pc_plus1}, 32'h011);
      chk("rst_instr", if_instr, 32'd0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("first_issue_en", {31'd0, imem_en}, 32'd1);
      chk("first_issue_addr", {22'd0, imem_addr}, 32'h010);
      fill_q(RPC);
      mon_en = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst_lat_gap", {31'd0, if_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("rst_lat_valid", {31'd0, if_valid}, 32'd1);
      chk("rst_lat_pc", {22'd0, if_pc}, 32'h010);
      repeat (8) begin
         @(negedge clk);
         chk("stream_valid", {31'd0, if_valid}, 32'd1);
      end
      tick();

      foreach (tbl[i]) begin
         redirect_to(tbl[i].target);
         @(negedge clk);
         chk("rd_gap", {31'd0, if_valid}, 32'd0);
         @(negedge clk);
         chk("rd_valid", {31'd0, if_valid}, 32'd1);
         chk("rd_pc", {22'd0, if_pc}, {22'd0, tbl[i].target});
         chk("rd_plus1", {22'd0, if_pc_plus1}, {22'd0, tbl[i].exp_plus1});
         chk("rd_instr", if_instr, tbl[i].exp_instr);
         repeat (3) @(negedge clk);
         tick();
      end

      // Stall at 0x005 for five cycles, then release.
      redirect_to(10'h000);
      wait_pc(10'h005, "wait_005");
      id_ready = 1'b0;
      iss = 0;
      repeat (5) begin
         @(negedge clk);
         if (imem_en) iss++;
         chk("stall_pc", {22'd0, if_pc}, 32'h005);
      end
      chk("stall_issue_le1", {31'd0, (iss <= 1)}, 32'd1);
      tick();
      id_ready = 1'b1;
      chk("release_valid", {31'd0, if_valid}, 32'd1);
      repeat (6) tick();

      // Redirect while stalled holding 0x008 with the skid full.
      redirect_to(10'h000);
      wait_pc(10'h008, "wait_008");
      id_ready = 1'b0;
      repeat (3) tick();
      redirect_to(10'h200);
      id_ready = 1'b1;
      @(negedge clk);
      chk("stall_rd_gap", {31'd0, if_valid}, 32'd0);
      @(negedge clk);
      chk("stall_rd_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_rd_pc", {22'd0, if_pc}, 32'h200);
      repeat (3) tick();

      // Redirect in the same cycle that 0x030 transfers.
      redirect_to(10'h028);
      cnt_30 = 0;
      wait_pc(10'h030, "wait_030");
      redirect_to(10'h100);
      @(negedge clk);
      chk("xfer_rd_gap", {31'd0, if_valid}, 32'd0);
      @(negedge clk);
      chk("xfer_rd_pc", {22'd0, if_pc}, 32'h100);
      repeat (3) tick();
      chk("xfer_030_once", cnt_30, 32'd1);

      // Reset asserted mid-stall with both slots full.
      id_ready = 1'b0;
      repeat (4) tick();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, if_valid}, 32'd0);
      chk("midrst_imem_en", {31'd0, imem_en}, 32'd0);
      chk("midrst_pc", {22'd0, if_pc}, 32'h010);
      @(negedge clk);
      #2;
      rst_n    = 1'b1;
      id_ready = 1'b1;
      fill_q(RPC);
      mon_en = 1'b1;
      #1;
      chk("midrst_issue_addr", {22'd0, imem_addr}, 32'h010);
      @(posedge clk); @(negedge clk);
      chk("midrst_gap", {31'd0, if_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("midrst_restart_pc", {22'd0, if_pc}, 32'h010);
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
